// File: rtl/fib_digit_scanner.sv
// Scans a packed BCD word one digit per clock through an external fib_rec, LSD first.
// Define FIB_SCAN_ABORT_EN to end the scan at the first non-BCD digit.
module fib_digit_scanner #(
  parameter int N_DIGITS = 4,
  localparam int CNT_W = $clog2(N_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*N_DIGITS-1:0]   bcd_word,
  output logic [3:0]              bcd_digit,
  input  logic                    fib_y,
  output logic                    busy,
  output logic                    done,
  output logic [N_DIGITS-1:0]     fib_mask,
  output logic [CNT_W-1:0]        fib_count,
  output logic                    invalid
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state;
  logic [4*N_DIGITS-1:0]   shadow;
  logic [IDX_W-1:0]        index;
  logic [3:0]              next_digit;
  logic                    last;
  logic                    digit_bad;
  logic                    accept;
  logic                    finish;

  assign last      = (index == IDX_W'(N_DIGITS - 1));
  assign digit_bad = (bcd_digit > 4'd9);
  assign accept    = start && ((state == IDLE) || (state == DONE));
`ifdef FIB_SCAN_ABORT_EN
  assign finish    = last || digit_bad;
`else
  assign finish    = last;
`endif

  // bcd_digit is registered, so the digit for index+1 is selected one edge early.
  always_comb begin
    next_digit = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (i == 32'(index) + 32'd1) next_digit = shadow[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      index     <= '0;
      bcd_digit <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fib_mask  <= '0;
      fib_count <= '0;
      invalid   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        shadow    <= bcd_word;
        bcd_digit <= bcd_word[3:0];
        index     <= '0;
        fib_mask  <= '0;
        fib_count <= '0;
        invalid   <= 1'b0;
        busy      <= 1'b1;
        state     <= SCAN;
      end else begin
        case (state)
          SCAN: begin
            if (digit_bad) begin
              fib_mask[index] <= 1'b0;
              invalid         <= 1'b1;
            end else begin
              fib_mask[index] <= fib_y;
              if (fib_y) fib_count <= fib_count + CNT_W'(1);
            end
            if (finish) begin
              bcd_digit <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              index     <= index + IDX_W'(1);
              bcd_digit <= next_digit;
            end
          end
          DONE: begin
            bcd_digit <= '0;
            state     <= IDLE;
          end
          default: begin
            bcd_digit <= '0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fib_digit_scanner.sv
// Directed bench for fib_digit_scanner (N_DIGITS=4) with a behavioural fib_rec on bcd_digit.
module tb_fib_digit_scanner;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] bcd_word;
  logic [3:0]  bcd_digit;
  logic        fib_y;
  logic        busy;
  logic        done;
  logic [3:0]  fib_mask;
  logic [2:0]  fib_count;
  logic        invalid;

  int pass_cnt;
  int total_cnt;
  int cyc;
  int dones;

  fib_digit_scanner #(.N_DIGITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bcd_word  (bcd_word),
    .bcd_digit (bcd_digit),
    .fib_y     (fib_y),
    .busy      (busy),
    .done      (done),
    .fib_mask  (fib_mask),
    .fib_count (fib_count),
    .invalid   (invalid)
  );

  // fib_rec: digits 0,1,2,3,5,8; non-BCD codes drive y=1 so ignoring them is observable.
  assign fib_y = (bcd_digit inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8}) || (bcd_digit > 4'd9);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Presents the word with start high for one edge; returns at the following falling edge (cycle 1).
  task automatic pulse_start(input logic [15:0] w);
    bcd_word = w;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic wait_done();
    while (!done && cyc < 20) tick();
  endtask

  task automatic check_results(input string tag, input int exp_cyc, input logic [3:0] m,
                               input logic [2:0] c, input logic inv);
    check({tag, "_done_cycle"}, cyc, exp_cyc);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    check({tag, "_mask"}, fib_mask, m);
    check({tag, "_count"}, fib_count, c);
    check({tag, "_invalid"}, invalid, inv);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    cyc       = 0;
    reset     = 1'b1;
    start     = 1'b0;
    bcd_word  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mask", fib_mask, 4'b0000);
    check("rst_count", fib_count, 3'd0);
    check("rst_digit", bcd_digit, 4'd0);

    // 1: basic scan, digit order LSD first
    pulse_start(16'h1234);
    check("t1_busy", busy, 1'b1);
    check("t1_digit0", bcd_digit, 4'd4);
    tick(); check("t1_digit1", bcd_digit, 4'd3);
    tick(); check("t1_digit2", bcd_digit, 4'd2);
    tick(); check("t1_digit3", bcd_digit, 4'd1);
    wait_done();
    check_results("t1", 5, 4'b1110, 3'd3, 1'b0);
    tick();
    check("t1_done_one_cycle", done, 1'b0);
    check("t1_mask_hold", fib_mask, 4'b1110);
    check("t1_idle_digit", bcd_digit, 4'd0);

    // 2: back-to-back start issued in the DONE cycle
    pulse_start(16'h0000);
    wait_done();
    check_results("t2a", 5, 4'b1111, 3'd4, 1'b0);
    pulse_start(16'h9764);
    check("t2_busy_immediate", busy, 1'b1);
    check("t2_done_cleared", done, 1'b0);
    check("t2_digit0", bcd_digit, 4'd4);
    check("t2_mask_cleared", fib_mask, 4'b0000);
    wait_done();
    check_results("t2b", 5, 4'b0000, 3'd0, 1'b0);
    tick();

    // 3: non-BCD digit at index 2
    pulse_start(16'h5A18);
    wait_done();
`ifdef FIB_SCAN_ABORT_EN
    check_results("t3", 4, 4'b0011, 3'd2, 1'b1);
`else
    check_results("t3", 5, 4'b1011, 3'd3, 1'b1);
`endif
    tick();
    check("t3_invalid_hold", invalid, 1'b1);

    // 4: start and bcd_word changes during SCAN are ignored
    pulse_start(16'h1234);
    tick();
    start    = 1'b1;
    bcd_word = 16'h0000;
    check("t4_digit1", bcd_digit, 4'd3);
    tick();
    check("t4_digit2", bcd_digit, 4'd2);
    tick();
    start = 1'b0;
    check("t4_digit3", bcd_digit, 4'd1);
    wait_done();
    check_results("t4", 5, 4'b1110, 3'd3, 1'b0);
    dones = 0;
    repeat (5) begin
      tick();
      if (done) dones++;
    end
    check("t4_extra_done_pulses", dones, 0);
    check("t4_idle_busy", busy, 1'b0);

    // 5: reset mid-scan discards the partial result
    pulse_start(16'h1234);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_mask", fib_mask, 4'b0000);
    check("t5_count", fib_count, 3'd0);
    check("t5_invalid", invalid, 1'b0);
    check("t5_digit", bcd_digit, 4'd0);
    pulse_start(16'h8888);
    wait_done();
    check_results("t5", 5, 4'b1111, 3'd4, 1'b0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
